tqvp_reg_arbiter: RTL and testbench
===================================

TQVP_REG_ARBITER -- requirements
Module: tqvp_reg_arbiter

Interface
REQ-001 The block SHALL have these ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 a_req, b_req  in  1 each  requester A (SPI host) / B (on-chip sequencer) access request.
REQ-004 a_we, b_we  in  1 each  1 = write, 0 = read.
REQ-005 a_addr, b_addr  in  4 each  peripheral register address.
REQ-006 a_wdata, b_wdata  in  8 each  write data.
REQ-007 a_gnt, b_gnt  out  1 each  one-cycle pulse: request accepted.
REQ-008 a_rvalid, b_rvalid  out  1 each  one-cycle pulse: read data valid.
REQ-009 a_rdata, b_rdata  out  8 each  read data, held until that requester's next read completes.
REQ-010 address  out  4  peripheral register address.
REQ-011 data_in  out  8  write data to peripheral.
REQ-012 data_write  out  1  one-cycle write strobe to peripheral.
REQ-013 data_out  in  8  peripheral read data, combinational from address.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, READ.
REQ-016 IDLE, any req high: arbitrate; register owner, addr, we, wdata; go to ACCESS next cycle.
REQ-017 IDLE, no req: remain in IDLE; address, data_in hold their last values.
REQ-018 ACCESS: drive address = registered addr, data_in = registered wdata; data_write = registered we for this cycle only; assert gnt of owner for this cycle only.
REQ-019 ACCESS next state: IDLE if write, READ if read.
REQ-020 READ: hold address; sample data_out into owner's rdata at end of cycle; go to IDLE.
REQ-021 Owner's rvalid SHALL pulse in the cycle after READ, coincident with that IDLE cycle.
REQ-022 Latency: write strobe 1 cycle after acceptance in IDLE; read rvalid 3 cycles after acceptance.
REQ-023 Throughput: back-to-back writes every 2 cycles; back-to-back reads every 3 cycles.
REQ-024 Requester SHALL hold req, we, addr, wdata stable until its gnt; req still high in the IDLE after gnt is a new request.
REQ-025 Both requesting in IDLE: round-robin; grant the requester that was not last owner.
REQ-026 Single requester SHALL be granted regardless of last owner; no idle cycles inserted.
REQ-027 Non-owner's gnt, rvalid, rdata SHALL be unaffected by owner's transactions.

Reset
REQ-028 rst high at a rising edge SHALL force IDLE at that edge regardless of state, abandoning any transaction in flight.
REQ-029 Reset values: address=0, data_in=0, data_write=0, gnt=0, rvalid=0, rdata=0, busy=0, last owner=B (A wins first tie).
REQ-030 A read interrupted by reset SHALL produce no rvalid; a write in ACCESS at reset SHALL produce no data_write.

Configuration
REQ-031 Macro REG_ARB_LOCK_EN SHALL compile in bus locking.
REQ-032 With REG_ARB_LOCK_EN: inputs a_lock, b_lock (1 bit each) exist; if owner's lock is high at its gnt, subsequent IDLE arbitration SHALL grant only that owner while its lock stays high; the other requester stalls.
REQ-033 With REG_ARB_LOCK_EN: lock deassertion SHALL release in the next IDLE; lock of a non-owner SHALL be ignored; reset clears lock state.
REQ-034 Without REG_ARB_LOCK_EN: lock ports SHALL be absent; pure round-robin.

Verification
REQ-035 A write addr=0x3 data=0xA5 alone -> a_gnt and data_write high together 1 cycle after acceptance, address=0x3, data_in=0xA5; busy for 1 cycle.
REQ-036 B read addr=0x7, peripheral returns 0x5C -> b_gnt at +1, b_rvalid at +3, b_rdata=0x5C; a_rdata unchanged at 0x00.
REQ-037 A and B hold writes continuously after reset -> grants alternate A,B,A,B every 2 cycles.
REQ-038 Reset asserted during READ of a B read -> no b_rvalid, all outputs 0 next cycle, next tie granted to A.
REQ-039 REG_ARB_LOCK_EN: A holds a_lock with 3 writes while B requests -> 3 A grants, B granted in IDLE after a_lock drops.
REQ-040 Single requester A issues read then write back-to-back -> acceptance-to-acceptance spacing 3 cycles, no bubble.

Source files
------------

// File: rtl/tqvp_reg_arbiter_if.sv
// tqvp_reg_arbiter_if: request/grant signals of both requesters plus the
// peripheral register bus. The arbiter connects through the slave modport;
// the requesters and the peripheral model sit on the master side.
// With REG_ARB_LOCK_EN defined, a_lock/b_lock are added.
//
// Handshake: a requester raises req with we/addr/wdata and holds them
// stable until it sees its gnt pulse. A req still high in the cycle after
// gnt counts as a new request. A read completes with a one-cycle rvalid
// pulse; rdata holds until that requester's next read completes.
interface tqvp_reg_arbiter_if;
  logic       a_req;
  logic       b_req;
  logic       a_we;
  logic       b_we;
  logic [3:0] a_addr;
  logic [3:0] b_addr;
  logic [7:0] a_wdata;
  logic [7:0] b_wdata;
  logic       a_gnt;
  logic       b_gnt;
  logic       a_rvalid;
  logic       b_rvalid;
  logic [7:0] a_rdata;
  logic [7:0] b_rdata;
  logic [3:0] address;
  logic [7:0] data_in;
  logic       data_write;
  logic [7:0] data_out;
  logic       busy;
  logic [1:0] dbg_state;
`ifdef REG_ARB_LOCK_EN
  logic       a_lock;
  logic       b_lock;
`endif

  modport slave (
`ifdef REG_ARB_LOCK_EN
    input  a_lock, b_lock,
`endif
    input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
    input  data_out,
    output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
    output address, data_in, data_write, busy, dbg_state
  );

  modport master (
`ifdef REG_ARB_LOCK_EN
    output a_lock, b_lock,
`endif
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
    output data_out,
    input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
    input  address, data_in, data_write, busy, dbg_state
  );
endinterface

// File: rtl/tqvp_reg_arbiter.sv
// tqvp_reg_arbiter: two-requester arbiter (A = SPI host, B = on-chip
// sequencer) in front of a single peripheral register bus.
// IDLE accepts one request, ACCESS drives the bus for one cycle (write
// strobe + gnt), READ captures data_out into the owner's rdata.
// Ties are broken round-robin against the last owner (B after reset).
// Optional macro REG_ARB_LOCK_EN adds bus locking via a_lock/b_lock.
module tqvp_reg_arbiter (
  input  logic                  clk,
  input  logic                  rst,
  tqvp_reg_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_READ   = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_owner_b;   // owner of current/last accepted transaction
  logic       r_we;
  logic [3:0] r_address;
  logic [7:0] r_data_in;
  logic       r_data_write;
  logic       r_a_gnt;
  logic       r_b_gnt;
  logic       r_a_rvalid;
  logic       r_b_rvalid;
  logic [7:0] r_a_rdata;
  logic [7:0] r_b_rdata;
  logic       r_busy;

  logic       w_elig_a;
  logic       w_elig_b;
  logic       w_pick_b;

`ifdef REG_ARB_LOCK_EN
  logic       r_locked;
  logic       w_lock_hold;

  // Lock stays in force only while the last owner keeps its lock high.
  assign w_lock_hold = r_locked & (r_owner_b ? bus.b_lock : bus.a_lock);
  assign w_elig_a    = bus.a_req & ~(w_lock_hold & r_owner_b);
  assign w_elig_b    = bus.b_req & ~(w_lock_hold & ~r_owner_b);
`else
  assign w_elig_a    = bus.a_req;
  assign w_elig_b    = bus.b_req;
`endif

  // B wins when alone, or on a tie when A owned the bus last.
  assign w_pick_b = w_elig_b & (~w_elig_a | ~r_owner_b);

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner_b    <= 1'b1;
      r_we         <= 1'b0;
      r_address    <= 4'h0;
      r_data_in    <= 8'h00;
      r_data_write <= 1'b0;
      r_a_gnt      <= 1'b0;
      r_b_gnt      <= 1'b0;
      r_a_rvalid   <= 1'b0;
      r_b_rvalid   <= 1'b0;
      r_a_rdata    <= 8'h00;
      r_b_rdata    <= 8'h00;
      r_busy       <= 1'b0;
`ifdef REG_ARB_LOCK_EN
      r_locked     <= 1'b0;
`endif
    end else begin
      r_a_gnt      <= 1'b0;
      r_b_gnt      <= 1'b0;
      r_data_write <= 1'b0;
      r_a_rvalid   <= 1'b0;
      r_b_rvalid   <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifdef REG_ARB_LOCK_EN
          if (!w_lock_hold) r_locked <= 1'b0;
`endif
          if (w_elig_a || w_elig_b) begin
            r_owner_b    <= w_pick_b;
            r_we         <= w_pick_b ? bus.b_we    : bus.a_we;
            r_address    <= w_pick_b ? bus.b_addr  : bus.a_addr;
            r_data_in    <= w_pick_b ? bus.b_wdata : bus.a_wdata;
            r_data_write <= w_pick_b ? bus.b_we    : bus.a_we;
            r_a_gnt      <= ~w_pick_b;
            r_b_gnt      <= w_pick_b;
            r_busy       <= 1'b1;
            r_state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
`ifdef REG_ARB_LOCK_EN
          r_locked <= r_owner_b ? bus.b_lock : bus.a_lock;
`endif
          r_busy  <= ~r_we;
          r_state <= r_we ? S_IDLE : S_READ;
        end
        S_READ: begin
          if (r_owner_b) begin
            r_b_rdata  <= bus.data_out;
            r_b_rvalid <= 1'b1;
          end else begin
            r_a_rdata  <= bus.data_out;
            r_a_rvalid <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.a_gnt      = r_a_gnt;
  assign bus.b_gnt      = r_b_gnt;
  assign bus.a_rvalid   = r_a_rvalid;
  assign bus.b_rvalid   = r_b_rvalid;
  assign bus.a_rdata    = r_a_rdata;
  assign bus.b_rdata    = r_b_rdata;
  assign bus.address    = r_address;
  assign bus.data_in    = r_data_in;
  assign bus.data_write = r_data_write;
  assign bus.busy       = r_busy;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_tqvp_reg_arbiter.sv
// tb_tqvp_reg_arbiter: cycle table for tqvp_reg_arbiter plus hand-written
// sequences for read latency and (with REG_ARB_LOCK_EN) bus locking.
module tb_tqvp_reg_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  tqvp_reg_arbiter_if bus ();

  tqvp_reg_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Peripheral model: combinational read data from address.
  logic [7:0] periph [16];
  assign bus.data_out = periph[bus.address];

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       a_req;
    logic       a_we;
    logic [3:0] a_addr;
    logic [7:0] a_wdata;
    logic       b_req;
    logic       b_we;
    logic [3:0] b_addr;
    logic [7:0] b_wdata;
    logic [5:0] e_flags;  // {a_gnt, b_gnt, a_rvalid, b_rvalid, data_write, busy}
    logic [3:0] e_addr;
    logic [7:0] e_din;
    logic [7:0] e_ard;
    logic [7:0] e_brd;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic r,
                              input logic ar, input logic aw, input logic [3:0] aa, input logic [7:0] ad,
                              input logic br, input logic bw, input logic [3:0] ba, input logic [7:0] bd,
                              input logic [5:0] fl, input logic [3:0] ea, input logic [7:0] ed,
                              input logic [7:0] eard, input logic [7:0] ebrd);
    vec_t v;
    v.rst = r; v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
    v.e_flags = fl; v.e_addr = ea; v.e_din = ed; v.e_ard = eard; v.e_brd = ebrd;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = 4'h0; bus.a_wdata = 8'h00;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 4'h0; bus.b_wdata = 8'h00;
`ifdef REG_ARB_LOCK_EN
    bus.a_lock = 1'b0; bus.b_lock = 1'b0;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [33:0] act_v;
    logic [33:0] exp_v;
    int          lat;
    int          gnt_lat;
    logic        got;

    checks   = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) periph[i] = 8'h30 + 8'(i);
    periph[7] = 8'h5C;
    rst = 1'b1;
    drive_idle();

    //                rst a_req we addr  wdata  b_req we addr  wdata   flags     addr  din    a_rd   b_rd
    vecs.push_back(mk(1, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 6'b000000,4'h0,8'h00,8'h00,8'h00)); // 0 reset
    vecs.push_back(mk(0, 1,1,4'h3,8'hA5, 0,0,4'h0,8'h00, 6'b100011,4'h3,8'hA5,8'h00,8'h00)); // 1 A write
    vecs.push_back(mk(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 6'b000000,4'h3,8'hA5,8'h00,8'h00)); // 2 hold
    vecs.push_back(mk(0, 0,0,4'h0,8'h00, 1,0,4'h7,8'h00, 6'b010001,4'h7,8'h00,8'h00,8'h00)); // 3 B read
    vecs.push_back(mk(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 6'b000001,4'h7,8'h00,8'h00,8'h00)); // 4 READ
    vecs.push_back(mk(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 6'b000100,4'h7,8'h00,8'h00,8'h5C)); // 5 rvalid
    vecs.push_back(mk(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 6'b000000,4'h7,8'h00,8'h00,8'h5C)); // 6 held
    vecs.push_back(mk(0, 1,1,4'h1,8'h11, 1,1,4'h2,8'h22, 6'b100011,4'h1,8'h11,8'h00,8'h5C)); // 7 tie->A
    vecs.push_back(mk(0, 1,1,4'h1,8'h11, 1,1,4'h2,8'h22, 6'b000000,4'h1,8'h11,8'h00,8'h5C)); // 8
    vecs.push_back(mk(0, 1,1,4'h1,8'h11, 1,1,4'h2,8'h22, 6'b010011,4'h2,8'h22,8'h00,8'h5C)); // 9 B
    vecs.push_back(mk(0, 1,1,4'h1,8'h11, 1,1,4'h2,8'h22, 6'b000000,4'h2,8'h22,8'h00,8'h5C)); // 10
    vecs.push_back(mk(0, 1,1,4'h1,8'h11, 1,1,4'h2,8'h22, 6'b100011,4'h1,8'h11,8'h00,8'h5C)); // 11 A
    vecs.push_back(mk(0, 1,1,4'h1,8'h11, 1,1,4'h2,8'h22, 6'b000000,4'h1,8'h11,8'h00,8'h5C)); // 12
    vecs.push_back(mk(0, 1,1,4'h1,8'h11, 1,1,4'h2,8'h22, 6'b010011,4'h2,8'h22,8'h00,8'h5C)); // 13 B
    vecs.push_back(mk(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 6'b000000,4'h2,8'h22,8'h00,8'h5C)); // 14
    vecs.push_back(mk(0, 1,0,4'h5,8'h00, 0,0,4'h0,8'h00, 6'b100001,4'h5,8'h00,8'h00,8'h5C)); // 15 A read
    vecs.push_back(mk(0, 1,1,4'h9,8'h99, 0,0,4'h0,8'h00, 6'b000001,4'h5,8'h00,8'h00,8'h5C)); // 16 READ
    vecs.push_back(mk(0, 1,1,4'h9,8'h99, 0,0,4'h0,8'h00, 6'b001000,4'h5,8'h00,8'h35,8'h5C)); // 17 rvalid
    vecs.push_back(mk(0, 1,1,4'h9,8'h99, 0,0,4'h0,8'h00, 6'b100011,4'h9,8'h99,8'h35,8'h5C)); // 18 no bubble
    vecs.push_back(mk(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 6'b000000,4'h9,8'h99,8'h35,8'h5C)); // 19
    vecs.push_back(mk(0, 0,0,4'h0,8'h00, 1,0,4'h7,8'h00, 6'b010001,4'h7,8'h00,8'h35,8'h5C)); // 20 B read
    vecs.push_back(mk(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 6'b000001,4'h7,8'h00,8'h35,8'h5C)); // 21 READ
    vecs.push_back(mk(1, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 6'b000000,4'h0,8'h00,8'h00,8'h00)); // 22 reset
    vecs.push_back(mk(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 6'b000000,4'h0,8'h00,8'h00,8'h00)); // 23 no rvalid
    vecs.push_back(mk(0, 1,1,4'h4,8'h44, 1,1,4'h6,8'h66, 6'b100011,4'h4,8'h44,8'h00,8'h00)); // 24 tie->A
    vecs.push_back(mk(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 6'b000000,4'h4,8'h44,8'h00,8'h00)); // 25

    foreach (vecs[i]) begin
      rst         = vecs[i].rst;
      bus.a_req   = vecs[i].a_req;   bus.a_we  = vecs[i].a_we;
      bus.a_addr  = vecs[i].a_addr;  bus.a_wdata = vecs[i].a_wdata;
      bus.b_req   = vecs[i].b_req;   bus.b_we  = vecs[i].b_we;
      bus.b_addr  = vecs[i].b_addr;  bus.b_wdata = vecs[i].b_wdata;
      step();
      act_v = {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.data_write, bus.busy,
               bus.address, bus.data_in, bus.a_rdata, bus.b_rdata};
      exp_v = {vecs[i].e_flags, vecs[i].e_addr, vecs[i].e_din, vecs[i].e_ard, vecs[i].e_brd};
      check($sformatf("row%0d", i), 64'(act_v), 64'(exp_v));
    end
    rst = 1'b0;
    drive_idle();

    // B read latency from acceptance: gnt at +1, rvalid at +3.
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 4'h7;
    lat = 0; gnt_lat = 0; got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      lat++;
      if (bus.b_gnt) begin
        gnt_lat   = lat;
        bus.b_req = 1'b0;
      end
      if (bus.b_rvalid) got = 1'b1;
    end
    check("rd_timeout", 64'(got), 64'd1);
    check("rd_gnt_lat", 64'(gnt_lat), 64'd1);
    check("rd_rvalid_lat", 64'(lat), 64'd3);
    check("rd_b_rdata", 64'(bus.b_rdata), 64'h5C);
    check("rd_a_rdata", 64'(bus.a_rdata), 64'h00);
    drive_idle();
    step();

`ifdef REG_ARB_LOCK_EN
    begin
      logic exp_q [$];
      int   na;
      logic done;
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q = '{1'b0, 1'b0, 1'b0, 1'b1};  // 0 = A, 1 = B
      bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 4'hA; bus.a_wdata = 8'h01; bus.a_lock = 1'b1;
      bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 4'hB; bus.b_wdata = 8'h02;
      na = 0; done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
        step();
        if (bus.a_gnt || bus.b_gnt) begin
          if (exp_q.size() == 0) begin
            check("lock_extra_gnt", 64'(bus.b_gnt), 64'd2);
            done = 1'b1;
          end else begin
            check($sformatf("lock_gnt%0d", 4 - exp_q.size()), 64'(bus.b_gnt), 64'(exp_q.pop_front()));
          end
          if (bus.a_gnt) begin
            na++;
            if (na == 3) begin bus.a_req = 1'b0; bus.a_lock = 1'b0; end
          end
          if (bus.b_gnt) begin bus.b_req = 1'b0; done = 1'b1; end
        end
      end
      check("lock_remaining", 64'(exp_q.size()), 64'd0);
      drive_idle();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
